// File: rtl/exception_sequencer.sv
// ---------------------------------------------------------------------------
// exception_sequencer : overflow / user-I/O exception entry and ERET sequencing
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module exception_sequencer #(
  parameter int                    DATA_WIDTH   = 16,
  parameter logic [DATA_WIDTH-1:0] HANDLER_ADDR = 16'h0100,
  parameter int                    CAUSE_WIDTH  = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   overflow,
  input  logic                   user_input,
  input  logic                   interrupts_enabled,
  input  logic [DATA_WIDTH-1:0]  pc_current,
  input  logic                   eret,
  input  logic [DATA_WIDTH-1:0]  epc_in,
  output logic                   cop_write,
  output logic [CAUSE_WIDTH-1:0] cause_out,
  output logic [DATA_WIDTH-1:0]  epc_out,
  output logic                   restore,
  output logic                   pc_redirect,
  output logic [DATA_WIDTH-1:0]  pc_target,
  output logic                   stall,
  output logic                   mode,
  output logic                   io_ack,
  output logic                   fault
);

  localparam logic [CAUSE_WIDTH-1:0] CAUSE_NONE = CAUSE_WIDTH'(0);
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_OVF  = CAUSE_WIDTH'(1);
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_IO   = CAUSE_WIDTH'(2);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RESTORE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CAUSE_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0]  epc_q, epc_d;
  logic                   pending_q, pending_d;
  logic                   fault_q, fault_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      epc_q     <= '0;
      pending_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;
    end
  end

  // A request still held at the acknowledge edge re-arms pending immediately.
  always_comb begin
    pending_d = pending_q;
    if (user_input && interrupts_enabled)
      pending_d = 1'b1;
    else if (state_q == ST_SAVE && cause_q == CAUSE_IO)
      pending_d = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    fault_d     = fault_q;
    cop_write   = 1'b0;
    cause_out   = CAUSE_NONE;
    epc_out     = '0;
    restore     = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    stall       = 1'b0;
    mode        = 1'b0;
    io_ack      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (overflow) begin
          cause_d = CAUSE_OVF;
          epc_d   = pc_current;
          state_d = ST_SAVE;
        end else if (pending_q) begin
          cause_d = CAUSE_IO;
          epc_d   = pc_current;
          state_d = ST_SAVE;
        end
      end
      ST_SAVE: begin
        cop_write = 1'b1;
        cause_out = cause_q;
        epc_out   = epc_q;
        stall     = 1'b1;
        io_ack    = (cause_q == CAUSE_IO);
        state_d   = ST_VECTOR;
      end
      ST_VECTOR: begin
        pc_redirect = 1'b1;
        pc_target   = HANDLER_ADDR;
        stall       = 1'b1;
        mode        = 1'b1;
        state_d     = ST_HANDLER;
      end
      ST_HANDLER: begin
        mode = 1'b1;
        if (overflow)
          fault_d = 1'b1;
        if (eret)
          state_d = ST_RESTORE;
      end
      ST_RESTORE: begin
        restore     = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = epc_in;
        stall       = 1'b1;
        mode        = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    fault = fault_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_exception_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exception_sequencer : directed + random checks against a behavioural model
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exception_sequencer;

  localparam logic [15:0] HANDLER = 16'h0100;

  logic        clk = 1'b0;
  logic        rn, ov, ui, ie, er;
  logic [15:0] pc, epc;
  logic        cop_write, restore, pc_redirect, stall, mode, io_ack, fault;
  logic [1:0]  cause_out;
  logic [15:0] epc_out, pc_target;

  int checks   = 0;
  int failures = 0;

  // Model: which step of the exception flow is due in the coming cycle.
  bit          m_save_due, m_vec_due, m_in_handler, m_restore_due;
  int          m_cause;
  logic [15:0] m_epc;
  bit          m_pending, m_fault;

  always #5 clk = ~clk;

  exception_sequencer #(
    .DATA_WIDTH(16), .HANDLER_ADDR(16'h0100), .CAUSE_WIDTH(2)
  ) dut (
    .clock(clk), .reset_n(rn), .overflow(ov), .user_input(ui),
    .interrupts_enabled(ie), .pc_current(pc), .eret(er), .epc_in(epc),
    .cop_write(cop_write), .cause_out(cause_out), .epc_out(epc_out),
    .restore(restore), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall(stall), .mode(mode), .io_ack(io_ack), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit busy_out;
    busy_out = m_save_due || m_vec_due || m_restore_due;
    chk("cop_write",   32'(cop_write),   32'(m_save_due));
    chk("cause_out",   32'(cause_out),   m_save_due ? 32'(m_cause) : 32'd0);
    chk("epc_out",     32'(epc_out),     m_save_due ? 32'(m_epc) : 32'd0);
    chk("io_ack",      32'(io_ack),      32'(m_save_due && m_cause == 2));
    chk("restore",     32'(restore),     32'(m_restore_due));
    chk("pc_redirect", 32'(pc_redirect), 32'(m_vec_due || m_restore_due));
    chk("pc_target",   32'(pc_target),
        m_vec_due ? 32'(HANDLER) : (m_restore_due ? 32'(epc) : 32'd0));
    chk("stall",       32'(stall),       32'(busy_out));
    chk("mode",        32'(mode),        32'(m_vec_due || m_in_handler || m_restore_due));
    chk("fault",       32'(fault),       32'(m_fault));
  endtask

  task automatic model_edge();
    bit idle, take_ovf, take_io, clear_io;
    if (!rn) begin
      m_save_due = 0; m_vec_due = 0; m_in_handler = 0; m_restore_due = 0;
      m_cause = 0; m_epc = '0; m_pending = 0; m_fault = 0;
      return;
    end
    idle     = !(m_save_due || m_vec_due || m_in_handler || m_restore_due);
    take_ovf = idle && ov;
    take_io  = idle && !ov && m_pending;
    clear_io = m_save_due && m_cause == 2;
    if (ui && ie)      m_pending = 1;
    else if (clear_io) m_pending = 0;
    if (m_restore_due) m_restore_due = 0;
    else if (m_in_handler) begin
      if (ov) m_fault = 1;
      if (er) begin m_in_handler = 0; m_restore_due = 1; end
    end else if (m_vec_due) begin
      m_vec_due = 0; m_in_handler = 1;
    end else if (m_save_due) begin
      m_save_due = 0; m_vec_due = 1;
    end else if (take_ovf || take_io) begin
      m_save_due = 1;
      m_cause    = take_ovf ? 1 : 2;
      m_epc      = pc;
    end
  endtask

  // Drive one cycle's inputs, check the current outputs, then advance past the edge.
  task automatic cycle(input logic r, input logic o, input logic u, input logic e,
                       input logic t, input logic [15:0] p, input logic [15:0] ep);
    rn = r; ov = o; ui = u; ie = e; er = t; pc = p; epc = ep;
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rn = 0; ov = 1; ui = 0; ie = 0; er = 0; pc = '0; epc = '0;
    @(posedge clk);
    model_edge();
    @(negedge clk);

    // Reset held with overflow asserted
    cycle(0, 1, 0, 0, 0, 16'h0042, 16'h0000);
    cycle(0, 1, 0, 0, 0, 16'h0042, 16'h0000);
    chk("rst_cop_write", 32'(cop_write), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    // Release with overflow at 0042
    cycle(1, 1, 0, 0, 0, 16'h0042, 16'h0000);
    chk("ovf_cop_write", 32'(cop_write), 32'd1);
    chk("ovf_cause", 32'(cause_out), 32'd1);
    chk("ovf_epc", 32'(epc_out), 32'h0042);
    cycle(1, 0, 0, 0, 0, 16'h0044, 16'h0042);
    chk("vec_redirect", 32'(pc_redirect), 32'd1);
    chk("vec_target", 32'(pc_target), 32'h0100);
    chk("vec_mode", 32'(mode), 32'd1);
    cycle(1, 0, 0, 0, 0, 16'h0100, 16'h0042);
    cycle(1, 1, 0, 0, 0, 16'h0102, 16'h0042);
    chk("hdl_fault", 32'(fault), 32'd1);
    cycle(1, 0, 0, 0, 1, 16'h0104, 16'h0042);
    chk("eret_restore", 32'(restore), 32'd1);
    chk("eret_redirect", 32'(pc_redirect), 32'd1);
    chk("eret_target", 32'(pc_target), 32'h0042);
    cycle(1, 0, 0, 0, 0, 16'h0042, 16'h0042);
    chk("post_restore", 32'(restore), 32'd0);
    chk("post_mode", 32'(mode), 32'd0);
    chk("fault_sticky", 32'(fault), 32'd1);
    cycle(0, 0, 0, 0, 0, 16'h0000, 16'h0000);

    // Simultaneous overflow and enabled I/O
    cycle(1, 1, 1, 1, 0, 16'h0010, 16'h0000);
    chk("sim_cause1", 32'(cause_out), 32'd1);
    chk("sim_no_ack", 32'(io_ack), 32'd0);
    cycle(1, 0, 0, 1, 0, 16'h0012, 16'h0010);
    cycle(1, 0, 0, 1, 0, 16'h0100, 16'h0010);
    cycle(1, 0, 0, 1, 1, 16'h0102, 16'h0010);
    chk("sim_restore_tgt", 32'(pc_target), 32'h0010);
    cycle(1, 0, 0, 1, 0, 16'h0010, 16'h0010);
    cycle(1, 0, 0, 1, 0, 16'h0012, 16'h0010);
    chk("sim_cause2", 32'(cause_out), 32'd2);
    chk("sim_io_ack", 32'(io_ack), 32'd1);
    cycle(1, 0, 0, 1, 0, 16'h0014, 16'h0012);
    cycle(1, 0, 0, 1, 0, 16'h0100, 16'h0012);
    cycle(1, 0, 0, 1, 1, 16'h0102, 16'h0012);
    cycle(1, 0, 0, 1, 0, 16'h0012, 16'h0012);

    // Masked I/O, then enabled
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 1, 0, 0, 16'h0200 + 16'(i), 16'h0000);
      chk("masked_no_write", 32'(cop_write), 32'd0);
    end
    cycle(1, 0, 1, 1, 0, 16'h0300, 16'h0000);
    cycle(1, 0, 1, 1, 0, 16'h0302, 16'h0000);
    chk("unmask_write", 32'(cop_write), 32'd1);
    chk("unmask_cause", 32'(cause_out), 32'd2);
    cycle(1, 0, 0, 1, 0, 16'h0304, 16'h0000);
    cycle(1, 0, 0, 1, 0, 16'h0100, 16'h0000);
    cycle(1, 0, 0, 1, 1, 16'h0102, 16'h0302);
    cycle(1, 0, 0, 1, 0, 16'h0302, 16'h0302);

    // Reset during VECTOR with I/O pending
    cycle(1, 1, 0, 0, 0, 16'h0400, 16'h0000);
    cycle(1, 0, 1, 1, 0, 16'h0402, 16'h0000);
    chk("mid_in_vector", 32'(pc_redirect), 32'd1);
    cycle(0, 0, 0, 0, 0, 16'h0404, 16'h0000);
    chk("mid_redirect", 32'(pc_redirect), 32'd0);
    chk("mid_mode", 32'(mode), 32'd0);
    cycle(1, 0, 0, 1, 0, 16'h0406, 16'h0000);
    chk("mid_pending_clr", 32'(cop_write), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 6) == 0),
            16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Initiator side of the coprocessor's save/restore interface.
- Detects overflow and user-I/O exception events and arbitrates between them.
- Drives the coprocessor's write strobe, cause and EPC value, and redirects the PC to the handler.
- On exception return, restores the backed-up mary/shelley registers and redirects the PC to the saved EPC.

Parameters:
- DATA_WIDTH, 16, width of PC, EPC and data paths.
- HANDLER_ADDR, 16'h0100, fixed handler entry address.
- CAUSE_WIDTH, 2, width of cause code.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- overflow  input  1  ALU overflow for the instruction at pc_current; sampled every cycle.
- user_input  input  1  level I/O interrupt request.
- interrupts_enabled  input  1  gates user_input only.
- pc_current  input  DATA_WIDTH  PC of the instruction in execute.
- eret  input  1  decoded exception-return instruction; one-cycle pulse.
- epc_in  input  DATA_WIDTH  current coprocessor EPC value.
- cop_write  output  1  write strobe to coprocessor mBack/sBack/epc/cause.
- cause_out  output  CAUSE_WIDTH  cause to store: 0 none, 1 overflow, 2 I/O.
- epc_out  output  DATA_WIDTH  EPC value to store.
- restore  output  1  selects mBack/sBack into mary/shelley this cycle.
- pc_redirect  output  1  PC mux takes pc_target this cycle.
- pc_target  output  DATA_WIDTH  redirect target.
- stall  output  1  freezes fetch/decode.
- mode  output  1  1 while in handler (kernel mode).
- io_ack  output  1  one-cycle acknowledge to the I/O source.
- fault  output  1  sticky: overflow taken while mode=1.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE. All outputs 0, io_pending=0, held EPC/cause regs 0. Reset mid-sequence aborts with no further strobes.
- io_pending: set on any edge where user_input=1 and interrupts_enabled=1. Cleared in SAVE when cause=2. The set has priority over a clear on the same edge only if the request is still asserted after io_ack.
- IDLE: stall=0, mode=0.
  - overflow=1 -> latch cause=1 and epc=pc_current, go to SAVE.
  - Otherwise, io_pending=1 -> latch cause=2 and epc=pc_current, go to SAVE.
  - Overflow beats I/O on the same cycle; I/O stays pending.
  - eret in IDLE is ignored.
- SAVE (1 cycle): cop_write=1, cause_out and epc_out driven from the latched regs, stall=1. io_ack=1 iff cause=2. Then go to VECTOR.
- VECTOR (1 cycle): pc_redirect=1, pc_target=HANDLER_ADDR, stall=1, mode=1. Then go to HANDLER.
- HANDLER: mode=1, stall=0. User I/O is not taken (no nesting) but keeps pending.
  - overflow=1 sets fault (sticky) and is otherwise ignored.
  - eret=1 -> go to RESTORE.
- RESTORE (1 cycle): restore=1, pc_redirect=1, pc_target=epc_in, stall=1, mode=1. Then go to IDLE.
  - A pending I/O may be taken from IDLE on the next cycle.
- Latency: event seen at edge N -> cop_write high in cycle N+1 -> redirect in cycle N+2.
- cause_out/epc_out/pc_target are 0 when their strobe is low.
- No arithmetic; all widths are DATA_WIDTH with no truncation.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with overflow=1 -> all outputs 0, state IDLE; release -> SAVE on the next edge.
- Overflow: pc_current=16'h0042, overflow pulse -> next cycle cop_write=1, cause_out=1, epc_out=0042; following cycle pc_redirect=1, pc_target=0100, mode=1.
- Simultaneous: overflow=1 and user_input=1 (enabled) at pc 0010 -> cause 1 is saved first. After eret and RESTORE (pc_target=epc_in=0010), the next IDLE cycle saves cause 2 with io_ack=1.
- Masked I/O: user_input=1 with interrupts_enabled=0 for 10 cycles -> no cop_write. Then enable -> SAVE with cause 2 within 2 cycles.
- Handler overflow/eret: in HANDLER assert overflow -> fault=1 and stays; eret -> restore=1 and pc_redirect=1 for exactly one cycle, then mode=0.
- Reset mid-sequence: reset_n=0 during VECTOR -> next cycle pc_redirect=0, mode=0, io_pending cleared.
